// File: rtl/grf_dump_reader_if.sv
// grf_dump_reader_if
//   Output stream of the GRF dump engine: one (index, value) pair per
//   transfer. A transfer happens on a rising edge where out_valid and
//   out_ready are both high.
//   out_valid  engine -> consumer  pair on out_idx/out_data is valid
//   out_ready  consumer -> engine  consumer accepts the pair this cycle
//   out_idx    engine -> consumer  register index of the pair
//   out_data   engine -> consumer  register value of the pair
//   master: the dump engine. slave: the consumer.
interface grf_dump_reader_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_idx;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_idx, output out_data, input out_ready);
   modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/grf_dump_reader.sv
// grf_dump_reader
//   Debug readback engine on a GRF read port. On start it walks the register
//   file from the first index up to NUM_REGS-1 and streams every
//   (index, value) pair over a valid/ready handshake.
//   clk        rising-edge clock, shared with the GRF
//   reset      synchronous, active-high
//   start      begin a dump; only looked at while idle
//   abort      cancel a dump in progress (also blocks start while idle)
//   grf_addr   GRF read address (A1); idx while walking, 0 when idle
//   grf_rdata  GRF read data (RD1), combinational on grf_addr
//   dump       output stream interface (master side)
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last pair is accepted
module grf_dump_reader #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter bit          SKIP_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] grf_addr,
   input  logic [DATA_W-1:0] grf_rdata,
   grf_dump_reader_if.master dump,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] idx, idx_next;
   logic [ADDR_W-1:0] out_idx_q, out_idx_next;
   logic [DATA_W-1:0] out_data_q, out_data_next;
   logic              out_valid_q, out_valid_next;
   logic              busy_q, busy_next;
   logic              done_q, done_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         out_idx_q   <= out_idx_next;
         out_data_q  <= out_data_next;
         out_valid_q <= out_valid_next;
         busy_q      <= busy_next;
         done_q      <= done_next;
      end
   end

   always_comb begin
      state_next     = state;
      idx_next       = idx;
      out_idx_next   = out_idx_q;
      out_data_next  = out_data_q;
      out_valid_next = out_valid_q;
      done_next      = 1'b0;

      case (state)
         IDLE: begin
            // abort outranks a simultaneous start
            if (start && !abort) begin
               idx_next   = FIRST_IDX;
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end else begin
               // snapshot is the value read this cycle; a GRF write landing
               // on this same edge is not seen
               out_data_next  = grf_rdata;
               out_idx_next   = idx;
               out_valid_next = 1'b1;
               state_next     = SEND;
            end
         end
         SEND: begin
            // abort drops the pair even if it is being accepted this cycle
            if (abort) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end else if (out_valid_q && dump.out_ready) begin
               out_valid_next = 1'b0;
               if (idx == LAST_IDX) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next   = idx + ADDR_W'(1);
                  state_next = LOAD;
               end
            end
         end
         default: begin
            out_valid_next = 1'b0;
            state_next     = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   assign grf_addr       = (state == IDLE) ? '0 : idx;
   assign dump.out_valid = out_valid_q;
   assign dump.out_idx   = out_idx_q;
   assign dump.out_data  = out_data_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
